// File: rtl/motor_cmd_sched.sv
// Four-motor ESC command scheduler: fixed-period update frames, arming sequence,
// and per-frame slew limiting of each motor speed toward its commanded target.
module motor_cmd_sched #(
  parameter int          FRAME_CYCLES = 5000,
  parameter int          SLEW_STEP    = 16,
  parameter int          ARM_FRAMES   = 4,
  parameter logic [10:0] IDLE_SPD     = 11'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        cmd_vld,
  input  logic [10:0] frnt_cmd,
  input  logic [10:0] bck_cmd,
  input  logic [10:0] lft_cmd,
  input  logic [10:0] rght_cmd,
  output logic [10:0] frnt_spd,
  output logic [10:0] bck_spd,
  output logic [10:0] lft_spd,
  output logic [10:0] rght_spd,
  output logic        wrt,
  output logic        armed
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int PC_W  = $clog2(ARM_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(ARM_FRAMES - 1);

  typedef enum logic [1:0] {DISARMED, ARMING, ARMED} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [PC_W-1:0]  pcnt_q, pcnt_d;
  logic             bnd;
  logic             arm_enter;
  logic [10:0]      cmd [4];
  logic [10:0]      tgt [4];
  logic [10:0]      spd [4];

  // One slew step in 12-bit arithmetic; the step never overshoots the target,
  // so the result stays within 11 bits, and the clamp guards against wrap.
  function automatic logic [10:0] slew(input logic [10:0] s, input logic [10:0] t);
    logic [11:0] s12, t12, d, step, r;
    s12  = {1'b0, s};
    t12  = {1'b0, t};
    step = 12'(SLEW_STEP);
    r    = s12;
    if (s12 < t12) begin
      d = t12 - s12;
      r = s12 + ((d < step) ? d : step);
    end else if (s12 > t12) begin
      d = s12 - t12;
      r = s12 - ((d < step) ? d : step);
    end
    return (r > 12'h7FF) ? 11'h7FF : r[10:0];
  endfunction

  function automatic logic [10:0] floor_idle(input logic [10:0] c);
    return (c < IDLE_SPD) ? IDLE_SPD : c;
  endfunction

  assign cmd[0] = frnt_cmd;
  assign cmd[1] = bck_cmd;
  assign cmd[2] = lft_cmd;
  assign cmd[3] = rght_cmd;

  assign bnd = (cnt == CNT_LAST);

  // Frame timer: free-running regardless of arming state
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wrt <= 1'b0;
    end else begin
      wrt <= bnd;
      cnt <= bnd ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DISARMED;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      DISARMED: begin
        pcnt_d = '0;
        if (arm) state_d = ARMING;
      end
      ARMING: begin
        if (!arm) begin
          state_d = DISARMED;
          pcnt_d  = '0;
        end else if (bnd) begin
          if (pcnt_q == PC_LAST) begin
            state_d = ARMED;
            pcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + PC_W'(1);
          end
        end
      end
      ARMED: begin
        pcnt_d = '0;
        if (!arm) state_d = DISARMED;
      end
      default: begin
        state_d = DISARMED;
        pcnt_d  = '0;
      end
    endcase
  end

  assign arm_enter = (state_q == ARMING) && (state_d == ARMED);

  // Speeds move only at frame boundaries; leaving ARMED zeroes everything at once
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        spd[i] <= '0;
        tgt[i] <= '0;
      end else if (state_q == ARMED && arm) begin
        if (bnd)     spd[i] <= slew(spd[i], tgt[i]);
        if (cmd_vld) tgt[i] <= floor_idle(cmd[i]);
      end else begin
        spd[i] <= '0;
        tgt[i] <= arm_enter ? IDLE_SPD : 11'd0;
      end
    end
  end

  assign frnt_spd = spd[0];
  assign bck_spd  = spd[1];
  assign lft_spd  = spd[2];
  assign rght_spd = spd[3];
  assign armed    = (state_q == ARMED);

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Bench for motor_cmd_sched: behavioural frame/arming/slew model compared every
// cycle, directed literal scenarios, then a randomized soak.
module tb_motor_cmd_sched;
  localparam int FC    = 40;
  localparam int STEP  = 16;
  localparam int ARMF  = 4;
  localparam int IDLE  = 64;

  logic        clk = 1'b0;
  logic        rst, arm, cmd_vld;
  logic [10:0] cmd_t [4];
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        wrt, armed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  motor_cmd_sched #(
    .FRAME_CYCLES(FC), .SLEW_STEP(STEP), .ARM_FRAMES(ARMF), .IDLE_SPD(11'(IDLE))
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .cmd_vld(cmd_vld),
    .frnt_cmd(cmd_t[0]), .bck_cmd(cmd_t[1]), .lft_cmd(cmd_t[2]), .rght_cmd(cmd_t[3]),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .wrt(wrt), .armed(armed)
  );

  // Behavioural model: edges since reset release decide frame boundaries
  bit m_valid = 0;
  int m_e, m_mode, m_p;   // mode 0 disarmed, 1 arming, 2 armed
  int m_tgt [4];
  int m_spd [4];
  bit m_wrt;

  function automatic int m_slew(int s, int t);
    if (s < t) return s + ((t - s) < STEP ? (t - s) : STEP);
    if (s > t) return s - ((s - t) < STEP ? (s - t) : STEP);
    return s;
  endfunction

  always @(posedge clk) begin
    bit bnd;
    if (rst) begin
      m_valid = 1; m_e = 0; m_mode = 0; m_p = 0; m_wrt = 0;
      for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_spd[i] = 0; end
    end else if (m_valid) begin
      m_e++;
      bnd   = (m_e % FC) == 0;
      m_wrt = bnd;
      case (m_mode)
        0: begin
          m_p = 0;
          if (arm) m_mode = 1;
        end
        1: begin
          if (!arm) begin m_mode = 0; m_p = 0; end
          else if (bnd) begin
            m_p++;
            if (m_p == ARMF) begin
              m_mode = 2; m_p = 0;
              for (int i = 0; i < 4; i++) m_tgt[i] = IDLE;
            end
          end
        end
        default: begin
          if (!arm) begin
            m_mode = 0;
            for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_spd[i] = 0; end
          end else begin
            if (bnd) for (int i = 0; i < 4; i++) m_spd[i] = m_slew(m_spd[i], m_tgt[i]);
            if (cmd_vld) for (int i = 0; i < 4; i++)
              m_tgt[i] = (int'(cmd_t[i]) < IDLE) ? IDLE : int'(cmd_t[i]);
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [45:0] act, exp;
    if (m_valid) begin
      act = {wrt, armed, frnt_spd, bck_spd, lft_spd, rght_spd};
      exp = {m_wrt, (m_mode == 2), 11'(m_spd[0]), 11'(m_spd[1]), 11'(m_spd[2]), 11'(m_spd[3])};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model t=%0t {wrt,armed,f,b,l,r} got %b %b %0d %0d %0d %0d expected %b %b %0d %0d %0d %0d",
                 $time, wrt, armed, frnt_spd, bck_spd, lft_spd, rght_spd,
                 m_wrt, m_mode == 2, m_spd[0], m_spd[1], m_spd[2], m_spd[3]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int v);
    chk(name, frnt_spd, v); chk(name, bck_spd, v);
    chk(name, lft_spd, v);  chk(name, rght_spd, v);
  endtask

  task automatic wait_wrt(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (wrt !== 1'b1 && n < 3 * FC);
    if (wrt !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wrt_timeout: got no wrt after %0d cycles expected one within %0d", n, FC);
    end
  endtask

  task automatic set_cmd(input logic [10:0] v);
    for (int i = 0; i < 4; i++) cmd_t[i] = v;
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; arm = 1'b1; cmd_vld = 1'b1;
    for (int i = 0; i < 4; i++) cmd_t[i] = 11'h3FF;
    repeat (3) @(negedge clk);
    chk_all("reset_spd", 0);
    chk("reset_wrt", wrt, 0);
    chk("reset_armed", armed, 0);
    rst = 1'b0; cmd_vld = 1'b0;

    wait_wrt(n); chk("first_wrt_latency", n, FC);
    wait_wrt(n); chk("wrt_period", n, FC);
    chk("armed_after_2", armed, 0);
    arm = 1'b0; @(negedge clk); arm = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wait_wrt(n);
      chk("arm_pulse_armed", armed, (k == 4));
      chk_all("arm_pulse_spd", 0);
    end

    set_cmd(11'h100);
    for (int k = 1; k <= 16; k++) begin wait_wrt(n); chk_all("slew_up", 16 * k); end
    for (int k = 0; k < 2; k++) begin wait_wrt(n); chk_all("hold_256", 256); end
    set_cmd(11'h005);
    for (int k = 1; k <= 12; k++) begin wait_wrt(n); chk_all("slew_down", 256 - 16 * k); end
    wait_wrt(n); chk_all("hold_idle", 64);

    set_cmd(11'h7F8);
    for (int k = 0; k < 200 && frnt_spd != 11'h7F8; k++) wait_wrt(n);
    chk_all("reach_7f8", 11'h7F8);
    set_cmd(11'h7FF);
    wait_wrt(n); chk_all("sat_7ff", 11'h7FF);
    wait_wrt(n); chk_all("sat_hold", 11'h7FF);

    arm = 1'b0; @(negedge clk);
    chk_all("disarm_spd", 0); chk("disarm_armed", armed, 0);
    arm = 1'b1;
    for (int k = 0; k < 4; k++) wait_wrt(n);
    chk("rearm", armed, 1);
    set_cmd(11'h100);
    for (int k = 0; k < 8; k++) wait_wrt(n);
    chk_all("rising_80", 11'h080);
    repeat (10) @(negedge clk);
    arm = 1'b0; @(negedge clk);
    chk_all("midslew_disarm_spd", 0); chk("midslew_disarm_armed", armed, 0);
    wait_wrt(n); chk("cadence_after_disarm", n, FC - 11);

    arm = 1'b1;
    for (int k = 0; k < 4; k++) wait_wrt(n);
    set_cmd(11'h100);
    for (int k = 0; k < 15; k++) wait_wrt(n);
    chk_all("race_pre_f0", 11'h0F0);
    repeat (FC - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) cmd_t[i] = 11'h200;
    cmd_vld = 1'b1; @(negedge clk); cmd_vld = 1'b0;
    chk("race_wrt", wrt, 1);
    chk_all("race_old_tgt", 11'h100);
    wait_wrt(n); chk_all("race_new_1", 11'h110);
    wait_wrt(n); chk_all("race_new_2", 11'h120);

    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      rst     = ($urandom_range(1999) == 0);
      cmd_vld = ($urandom_range(7) == 0);
      if ($urandom_range(299) == 0) arm = ~arm;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(5))
          0:       cmd_t[i] = 11'h7FF;
          1:       cmd_t[i] = 11'(IDLE - 1 - $urandom_range(10));
          default: cmd_t[i] = 11'($urandom_range(2047));
        endcase
      end
    end
    rst = 1'b0; cmd_vld = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/motor_cmd_sched.md
MOTOR_CMD_SCHED -- requirements
Module: motor_cmd_sched

Interface
REQ-001 Parameter FRAME_CYCLES, default 5000, SHALL set the ESC update frame period in clk cycles.
REQ-002 Parameter SLEW_STEP, default 16, SHALL set the max per-frame change of any speed output.
REQ-003 Parameter ARM_FRAMES, default 4, SHALL set the number of zero-speed frames sent before ARMED.
REQ-004 Parameter IDLE_SPD, default 11'd64, SHALL set the minimum target speed while ARMED.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-006 rst  input  1  SHALL be the reset; synchronous, active-high.
REQ-007 arm  input  1  SHALL be the level request to arm motors (1) or disarm (0).
REQ-008 cmd_vld  input  1  SHALL be a one-cycle strobe qualifying the four command inputs.
REQ-009 frnt_cmd, bck_cmd, lft_cmd, rght_cmd  input  11 each  SHALL be unsigned target speeds.
REQ-010 frnt_spd, bck_spd, lft_spd, rght_spd  output  11 each  SHALL be registered SPEED values to the four ESC interfaces.
REQ-011 wrt  output  1  SHALL be a registered one-cycle pulse, shared by all four ESC interfaces, marking a new speed set.
REQ-012 armed  output  1  SHALL be high only in state ARMED.

Function
REQ-013 Frame counter SHALL count 0..FRAME_CYCLES-1 and wrap to 0; it SHALL run in every state.
REQ-014 wrt SHALL be 1 on the cycle after the counter equals FRAME_CYCLES-1; pulse period exactly FRAME_CYCLES; never two consecutive cycles high.
REQ-015 Speed outputs SHALL update only on the edge where wrt rises (frame boundary), except forced zeroing (REQ-021), so speeds are stable while wrt is high.
REQ-016 States SHALL be DISARMED, ARMING, ARMED.
REQ-017 DISARMED: speeds held 0, targets held 0, wrt still pulses; arm=1 -> ARMING next cycle.
REQ-018 ARMING: speeds 0, cmd_vld ignored; count wrt pulses; on the ARM_FRAMES-th pulse -> ARMED; arm=0 -> DISARMED next cycle, pulse count cleared.
REQ-019 ARMED: cmd_vld SHALL capture each target as max(cmd, IDLE_SPD); speeds slew only from the first boundary after entering ARMED.
REQ-020 Slew at each boundary, per motor: spd<tgt -> spd+min(SLEW_STEP, tgt-spd); spd>tgt -> spd-min(SLEW_STEP, spd-tgt); equal -> hold; arithmetic SHALL be 12-bit internally, result never exceeds 11'h7FF nor wraps.
REQ-021 ARMED with arm=0 SHALL go to DISARMED; speeds, targets forced to 0 on the next edge (no slew), armed=0 same edge.
REQ-022 cmd_vld on the same cycle as a boundary: slew uses old targets; new targets take effect at next boundary.
REQ-023 Multiple cmd_vld within one frame: last one wins.
REQ-024 Frame counter and wrt timing SHALL be unaffected by state transitions.

Reset
REQ-025 rst=1 at a clock edge SHALL set state DISARMED, counter 0, pulse count 0, targets 0, all speeds 0, wrt 0, armed 0; applies mid-frame and mid-slew.
REQ-026 After rst falls, first wrt SHALL occur exactly FRAME_CYCLES cycles later (cycle index FRAME_CYCLES counting the first non-reset edge as 1).

Verification
REQ-027 Reset: hold rst 3 cycles with arm=1, cmd_vld=1 -> all speeds 0, wrt 0, armed 0; first wrt 5000 cycles after release, then every 5000.
REQ-028 Arming: arm=1 after reset -> 4 wrt pulses with speeds 0, armed=1 coincident with 4th pulse; arm dropped after 2 pulses -> DISARMED, re-arm needs 4 fresh pulses.
REQ-029 Slew up: armed, cmd all 11'h100 -> speeds 16,32,...,256 over 16 consecutive frames, then hold 256; cmd 11'h005 -> target 64, speeds fall 16/frame to 64.
REQ-030 Saturation: speed 11'h7F8, cmd 11'h7FF -> next frame 11'h7FF, subsequent frames hold 11'h7FF, no wrap to low values.
REQ-031 Disarm mid-slew: speeds 11'h080 rising, arm=0 mid-frame -> next edge all speeds 0, armed 0; wrt cadence unchanged.
REQ-032 Boundary race: cmd_vld with 11'h200 on wrt cycle while target 11'h100 at 11'h0F0 -> that frame 11'h100, following frames step 16 toward 11'h200.
